// File: rtl/pbkdf2_f_block.sv
// PBKDF2 F-function iteration controller: chains c HMAC requests through an
// external hmac_sha256 core and XOR-accumulates every Uj into the result T.
module pbkdf2_f_block #(
  parameter int unsigned iter_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    v_i,
  output logic                    r_o,
  input  logic [255:0]            key_i,
  input  logic [255:0]            salt_i,
  input  logic [iter_width_p-1:0] iter_i,
  output logic                    v_o,
  input  logic                    r_i,
  output logic [255:0]            dk_o,
  output logic                    hmac_v_o,
  input  logic                    hmac_r_i,
  output logic [255:0]            hmac_prf_o,
  output logic [255:0]            hmac_salt_o,
  input  logic                    hmac_v_i,
  output logic                    hmac_r_o,
  input  logic [255:0]            hmac_prf_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [255:0]            key_q, key_d;
  logic [255:0]            msg_q, msg_d;
  logic [255:0]            acc_q, acc_d;
  logic [iter_width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    msg_d   = msg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          key_d   = key_i;
          msg_d   = salt_i;
          acc_d   = '0;
          // c=0 is treated as a single iteration so the counter never wraps
          cnt_d   = (iter_i == '0) ? iter_width_p'(1) : iter_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hmac_r_i) state_d = WAIT;
      end
      WAIT: begin
        if (hmac_v_i) begin
          acc_d   = acc_q ^ hmac_prf_i;
          msg_d   = hmac_prf_i;
          cnt_d   = cnt_q - iter_width_p'(1);
          state_d = (cnt_q == iter_width_p'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (r_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      msg_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign r_o         = (state_q == IDLE);
  assign hmac_v_o    = (state_q == ISSUE);
  assign hmac_r_o    = (state_q == WAIT);
  assign v_o         = (state_q == DONE);
  assign hmac_prf_o  = key_q;
  assign hmac_salt_o = msg_q;
  assign dk_o        = acc_q;

endmodule

// File: tb/tb_pbkdf2_f_block.sv
// Directed bench for pbkdf2_f_block with a stub HMAC core returning key ^ msg
// one cycle after each request; expectations flow through scoreboard queues.
module tb_pbkdf2_f_block;

  logic         clk = 1'b0;
  logic         rst_i, v_i, r_o, v_o, r_i;
  logic [255:0] key_i, salt_i, dk_o;
  logic [31:0]  iter_i;
  logic         hmac_v_o, hmac_r_i, hmac_v_i, hmac_r_o;
  logic [255:0] hmac_prf_o, hmac_salt_o, hmac_prf_i;

  localparam logic [255:0] K = 256'h01;
  localparam logic [255:0] S = 256'hF0;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [255:0] exp_salt_q[$];
  logic [255:0] exp_dk_q[$];
  int unsigned  exp_nreq_q[$];

  int unsigned  stall_cfg = 0;
  bit           spur_req  = 1'b0;
  int unsigned  req_cnt   = 0;

  pbkdf2_f_block #(.iter_width_p(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .v_i(v_i), .r_o(r_o),
    .key_i(key_i), .salt_i(salt_i), .iter_i(iter_i),
    .v_o(v_o), .r_i(r_i), .dk_o(dk_o),
    .hmac_v_o(hmac_v_o), .hmac_r_i(hmac_r_i),
    .hmac_prf_o(hmac_prf_o), .hmac_salt_o(hmac_salt_o),
    .hmac_v_i(hmac_v_i), .hmac_r_o(hmac_r_o), .hmac_prf_i(hmac_prf_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: chained U values are key ^ previous message.
  task automatic push_job(input logic [31:0] c);
    int unsigned  ce;
    logic [255:0] m, u, acc;
    ce  = (c == 0) ? 1 : c;
    m   = S;
    acc = '0;
    for (int unsigned i = 0; i < ce; i++) begin
      exp_salt_q.push_back(m);
      u   = K ^ m;
      acc = acc ^ u;
      m   = u;
    end
    exp_dk_q.push_back(acc);
    exp_nreq_q.push_back(ce);
  endtask

  // Stub core: all decisions made on the falling edge, away from the DUT edge.
  initial begin
    bit           pend;
    logic [255:0] pend_data, held_salt;
    int unsigned  stall_cnt;
    pend = 1'b0; pend_data = '0; held_salt = '0; stall_cnt = 0;
    hmac_v_i = 1'b0; hmac_r_i = 1'b0; hmac_prf_i = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        hmac_v_i = 1'b0; hmac_r_i = 1'b0; pend = 1'b0; stall_cnt = 0;
      end else begin
        if (hmac_v_i) hmac_v_i = 1'b0;
        if (pend) begin
          hmac_v_i   = 1'b1;
          hmac_prf_i = pend_data;
          pend       = 1'b0;
          check("resp_ready", 256'(hmac_r_o), 256'(1'b1));
        end
        hmac_r_i = 1'b0;
        if (hmac_v_o) begin
          if (stall_cnt < stall_cfg) begin
            if (stall_cnt == 0) held_salt = hmac_salt_o;
            else check("req_hold", hmac_salt_o, held_salt);
            stall_cnt++;
            if (spur_req && !hmac_v_i) begin
              hmac_v_i   = 1'b1;
              hmac_prf_i = 256'hFFFF;
              spur_req   = 1'b0;
              check("spur_not_ready", 256'(hmac_r_o), 256'(1'b0));
            end
          end else begin
            if (stall_cfg > 0) check("req_hold_end", hmac_salt_o, held_salt);
            hmac_r_i  = 1'b1;
            stall_cnt = 0;
            req_cnt++;
            check("req_key", hmac_prf_o, K);
            if (exp_salt_q.size() == 0) check("req_unexpected", 256'(1'b1), 256'(exp_salt_q.size()));
            else check("req_salt", hmac_salt_o, exp_salt_q.pop_front());
            pend      = 1'b1;
            pend_data = hmac_prf_o ^ hmac_salt_o;
          end
        end
      end
    end
  end

  task automatic run_job(input logic [31:0] c, input int unsigned stall,
                         input int unsigned dstall, input bit hold_vi, input bit spur);
    logic [255:0] first;
    stall_cfg = stall;
    spur_req  = spur;
    @(negedge clk);
    check("idle_ready", 256'(r_o), 256'(1'b1));
    v_i = 1'b1; iter_i = c;
    push_job(c);
    @(negedge clk);
    if (!hold_vi) v_i = 1'b0;
    check("req_latency", 256'(hmac_v_o), 256'(1'b1));
    check("busy_not_ready", 256'(r_o), 256'(1'b0));
    for (int n = 0; n < 400 && !v_o; n++) @(negedge clk);
    check("done_timeout", 256'(v_o), 256'(1'b1));
    first = dk_o;
    for (int unsigned i = 0; i < dstall; i++) begin
      @(negedge clk);
      check("dk_hold", dk_o, first);
      check("v_hold", 256'(v_o), 256'(1'b1));
    end
    r_i = 1'b1; v_i = 1'b0;
    if (exp_dk_q.size() != 0) begin
      check("dk", dk_o, exp_dk_q.pop_front());
      check("req_count", 256'(req_cnt), 256'(exp_nreq_q.pop_front()));
    end
    req_cnt = 0;
    @(negedge clk);
    r_i = 1'b0;
    check("ready_after_result", 256'(r_o), 256'(1'b1));
    check("v_after_result", 256'(v_o), 256'(1'b0));
    stall_cfg = 0;
  endtask

  initial begin
    rst_i = 1'b1; v_i = 1'b1; r_i = 1'b0;
    key_i = K; salt_i = S; iter_i = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_r_o", 256'(r_o), 256'(1'b1));
      check("rst_outs", {dk_o | hmac_prf_o | hmac_salt_o},  '0);
      check("rst_valids", 256'({v_o, hmac_v_o, hmac_r_o}), '0);
    end
    rst_i = 1'b0; v_i = 1'b0;

    run_job(32'd1, 0, 0, 1'b0, 1'b0);
    run_job(32'd2, 0, 0, 1'b0, 1'b0);
    run_job(32'd3, 0, 0, 1'b0, 1'b0);
    run_job(32'd0, 0, 0, 1'b0, 1'b0);
    run_job(32'd2, 5, 4, 1'b1, 1'b0);
    run_job(32'd2, 2, 0, 1'b0, 1'b1);

    // Reset while waiting on the core mid-job
    @(negedge clk);
    v_i = 1'b1; iter_i = 32'd1000;
    push_job(32'd1000);
    @(negedge clk);
    v_i = 1'b0;
    for (int n = 0; n < 20 && !hmac_r_o; n++) @(negedge clk);
    check("midjob_wait", 256'(hmac_r_o), 256'(1'b1));
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_r_o", 256'(r_o), 256'(1'b1));
    check("midrst_hmac_v_o", 256'(hmac_v_o), 256'(1'b0));
    check("midrst_v_o", 256'(v_o), 256'(1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    exp_salt_q.delete();
    exp_dk_q.delete();
    exp_nreq_q.delete();
    req_cnt = 0;

    run_job(32'd1, 0, 0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
